// File: rtl/fifo_event_sequencer.sv
// Event framing around a single-clock sample FIFO: header + N samples are written only when the whole
// event fits, and only complete events are drained to a valid/ready stream through a 2-entry skid buffer.
module fifo_event_sequencer #(
    parameter int DEPTH  = 16384,
    parameter int CNT_W  = 15,
    parameter int LEN_W  = 14,
    parameter int RD_LAT = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             arm_i,
    input  logic             disarm_i,
    input  logic             continuous_i,
    input  logic [LEN_W-1:0] sample_count_i,
    input  logic             trig_in_i,
    input  logic             sample_valid_i,
    input  logic [15:0]      sample_data_i,
    output logic             fifo_we_o,
    output logic [17:0]      fifo_data_o,
    input  logic [CNT_W-1:0] fifo_wrcnt_i,
    input  logic             fifo_full_i,
    input  logic             fifo_empty_i,
    output logic             fifo_re_o,
    input  logic [17:0]      fifo_q_i,
    output logic [17:0]      out_data_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic [15:0]      event_cnt_o,
    output logic [15:0]      drop_cnt_o
);

    localparam logic [1:0] TAG_HDR  = 2'b10;
    localparam logic [1:0] TAG_SMP  = 2'b00;
    localparam logic [1:0] TAG_LAST = 2'b01;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_HDR, S_CAPT} state_e;
    state_e state_q, state_d;

    logic [LEN_W-1:0] len_q, scnt_q;
    logic             cont_q, disarm_seen_q;
    logic [15:0]      event_cnt_q, drop_cnt_q, pending_q;
    logic             space_ok, arm_ok, cap_word, cap_last, drop_ev;
    logic             pending_inc, pending_dec;

    // Space check is done in 16 bits so WRCNT + LEN + 1 cannot wrap.
    assign space_ok = (16'(fifo_wrcnt_i) + 16'(len_q) + 16'd1) <= 16'(DEPTH);
    assign arm_ok   = (state_q == S_IDLE) && arm_i && (pending_q == 16'd0);
    assign cap_word = (state_q == S_CAPT) && sample_valid_i;
    assign cap_last = cap_word && (scnt_q == len_q - LEN_W'(1));
    assign drop_ev  = trig_in_i && (((state_q == S_ARMED) && !space_ok) ||
                                    (state_q == S_HDR) || (state_q == S_CAPT));

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arm_ok) state_d = S_ARMED;
            S_ARMED: begin
                if (disarm_i)                    state_d = S_IDLE;
                else if (trig_in_i && space_ok)  state_d = S_HDR;
            end
            S_HDR:   state_d = S_CAPT;
            S_CAPT:  if (cap_last)
                         state_d = (cont_q && !disarm_seen_q && !disarm_i) ? S_ARMED : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_we_o   = 1'b0;
        fifo_data_o = {TAG_SMP, sample_data_i};
        case (state_q)
            S_HDR: begin
                fifo_we_o   = 1'b1;
                fifo_data_o = {TAG_HDR, event_cnt_q};
            end
            S_CAPT: begin
                fifo_we_o   = sample_valid_i;
                fifo_data_o = {(cap_last ? TAG_LAST : TAG_SMP), sample_data_i};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            len_q         <= '0;
            cont_q        <= 1'b0;
            disarm_seen_q <= 1'b0;
            scnt_q        <= '0;
            event_cnt_q   <= '0;
            drop_cnt_q    <= '0;
        end else begin
            if (arm_ok) begin
                len_q         <= sample_count_i;
                cont_q        <= continuous_i;
                disarm_seen_q <= 1'b0;
            end
            // A disarm during capture is held until the event closes.
            if (((state_q == S_HDR) || (state_q == S_CAPT)) && disarm_i) disarm_seen_q <= 1'b1;
            if (cap_last) disarm_seen_q <= 1'b0;
            if (state_q == S_HDR)  scnt_q <= '0;
            else if (cap_word)     scnt_q <= scnt_q + LEN_W'(1);
            if (cap_last) event_cnt_q <= event_cnt_q + 16'd1;
            if (drop_ev && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    logic [RD_LAT:1]   vld_pipe_q;
    logic [1:0][17:0]  skid_q;
    logic              skid_wr_q, skid_rd_q;
    logic [1:0]        occ_q;
    logic [CNT_W-1:0]  words_q;
    logic              land, pop;
    logic [2:0]        inflight;

    assign land        = vld_pipe_q[RD_LAT];
    assign inflight    = 3'($countones(vld_pipe_q));
    assign out_valid_o = (occ_q != 2'd0);
    assign out_data_o  = skid_q[skid_rd_q];
    assign out_last_o  = out_valid_o && (out_data_o[17:16] == TAG_LAST);
    assign pop         = out_valid_o && out_ready_i;
    assign pending_inc = cap_last;
    assign pending_dec = pop && out_last_o;

    // A pop this cycle frees a slot, which keeps the stream at one word per cycle.
    assign fifo_re_o = (pending_q != 16'd0) && !fifo_empty_i &&
                       ((3'(occ_q) + inflight) < (3'd2 + 3'(pop))) &&
                       (words_q < (CNT_W'(len_q) + CNT_W'(1)));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_pipe_q <= '0;
            skid_q     <= '0;
            skid_wr_q  <= 1'b0;
            skid_rd_q  <= 1'b0;
            occ_q      <= 2'd0;
            words_q    <= '0;
            pending_q  <= '0;
        end else begin
            vld_pipe_q[1] <= fifo_re_o;
            for (int i = 2; i <= RD_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
            if (land) begin
                skid_q[skid_wr_q] <= fifo_q_i;
                skid_wr_q         <= ~skid_wr_q;
            end
            if (pop) skid_rd_q <= ~skid_rd_q;
            occ_q <= occ_q + 2'(land) - 2'(pop);
            if (pending_dec)    words_q <= '0;
            else if (fifo_re_o) words_q <= words_q + CNT_W'(1);
            if (pending_inc && !pending_dec)      pending_q <= pending_q + 16'd1;
            else if (!pending_inc && pending_dec) pending_q <= pending_q - 16'd1;
        end
    end

    assign busy_o      = (state_q != S_IDLE) || (pending_q != 16'd0);
    assign event_cnt_o = event_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;

    a_no_write_when_full: assert property (@(posedge clk_i) disable iff (reset_i)
                                           !(fifo_we_o && fifo_full_i));

endmodule

// File: tb/tb_fifo_event_sequencer.sv
// Scoreboard bench: a queue-based FIFO model feeds the DUT; expected stream words are queued at stimulus time
// and a negedge monitor pops and compares every accepted output word.
module tb_fifo_event_sequencer;
    localparam int DEPTH = 16384;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, arm = 1'b0, disarm = 1'b0, continuous = 1'b0;
    logic [13:0] sample_count = '0;
    logic        trig = 1'b0, svalid = 1'b0;
    logic [15:0] sdata = '0;
    logic        fifo_we, fifo_full, fifo_empty, fifo_re;
    logic [17:0] fifo_data, fifo_q;
    logic [14:0] fifo_wrcnt;
    logic [17:0] out_data;
    logic        out_valid, out_last, out_ready, busy;
    logic [15:0] event_cnt, drop_cnt;

    int checks = 0, errors = 0;
    logic [18:0] exp_q[$];
    logic [17:0] fmem[$];
    int fsize = 0, fake_fill = 0, we_count = 0, full_viol = 0;
    int mdl_ev = 0, mdl_drop = 0;
    bit rnd_ready = 1'b0;

    fifo_event_sequencer dut (
        .clk_i(clk), .reset_i(reset), .arm_i(arm), .disarm_i(disarm),
        .continuous_i(continuous), .sample_count_i(sample_count), .trig_in_i(trig),
        .sample_valid_i(svalid), .sample_data_i(sdata),
        .fifo_we_o(fifo_we), .fifo_data_o(fifo_data), .fifo_wrcnt_i(fifo_wrcnt),
        .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty), .fifo_re_o(fifo_re),
        .fifo_q_i(fifo_q), .out_data_o(out_data), .out_valid_o(out_valid),
        .out_last_o(out_last), .out_ready_i(out_ready), .busy_o(busy),
        .event_cnt_o(event_cnt), .drop_cnt_o(drop_cnt)
    );

    // fake_fill stands in for words already sitting in the FIFO, so fill-level corner cases stay short.
    assign fifo_wrcnt = 15'(fsize + fake_fill);
    assign fifo_full  = (fsize + fake_fill) >= DEPTH;
    assign fifo_empty = (fsize == 0);

    always @(posedge clk) begin
        if (reset) begin
            fmem.delete();
            fsize  <= 0;
            fifo_q <= '0;
        end else begin
            if (fifo_we) begin
                if (fifo_full) full_viol++;
                fmem.push_back(fifo_data);
                we_count++;
            end
            if (fifo_re && fmem.size() > 0) fifo_q <= fmem.pop_front();
            fsize <= fmem.size();
        end
    end

    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    bit          stall_q = 1'b0;
    logic [18:0] stall_w, mon_e;
    always @(negedge clk) begin
        if (reset) stall_q = 1'b0;
        else begin
            if (stall_q) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_word", 32'({out_last, out_data}), 32'(stall_w));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_extra actual=0x%0h required=no word", {out_last, out_data});
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream_word", 32'({out_last, out_data}), 32'(mon_e));
                end
            end
            stall_q = out_valid && !out_ready;
            stall_w = {out_last, out_data};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input int n, input bit cont);
        sample_count = 14'(n);
        continuous   = cont;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Trigger is sampled in ARMED, the next cycle is the header, samples are taken from the cycle after.
    task automatic run_event(input int n, input int vpct, input bit seq, input int trig_at, input int disarm_at);
        bit acc, tf, df;
        int i;
        acc = (fsize + fake_fill + n + 1) <= DEPTH;
        if (acc) exp_q.push_back({1'b0, 2'b10, 16'(mdl_ev)});
        else     mdl_drop++;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        i = 0; tf = 1'b0; df = 1'b0;
        while (i < n) begin
            svalid = ($urandom_range(99, 0) < vpct);
            sdata  = seq ? 16'(i + 1) : 16'($urandom);
            trig   = (!tf && i == trig_at);
            if (trig) begin tf = 1'b1; mdl_drop++; end
            disarm = (!df && i == disarm_at);
            if (disarm) df = 1'b1;
            if (svalid) begin
                if (acc) exp_q.push_back({(i == n - 1), ((i == n - 1) ? 2'b01 : 2'b00), sdata});
                i++;
            end
            tick();
        end
        svalid = 1'b0; trig = 1'b0; disarm = 1'b0;
        if (acc) mdl_ev++;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 5000) begin tick(); k++; end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d words left required=0", exp_q.size());
        end
        repeat (3) tick();
    endtask

    initial begin
        int we0, n;
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_fifo_we",   32'(fifo_we),   32'd0);
        chk("rst_fifo_re",   32'(fifo_re),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_event_cnt", 32'(event_cnt), 32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),  32'd0);

        // T1: single shot, N=4, samples 1..4
        do_arm(4, 1'b0);
        chk("t1_busy_armed", 32'(busy), 32'd1);
        we0 = we_count;
        run_event(4, 100, 1'b1, -1, -1);
        drain();
        chk("t1_fifo_writes", 32'(we_count - we0), 32'd5);
        chk("t1_event_cnt", 32'(event_cnt), 32'(mdl_ev));
        chk("t1_busy_done", 32'(busy), 32'd0);

        // T2: continuous, N=3, gappy samples
        do_arm(3, 1'b1);
        for (int e = 0; e < 3; e++) begin
            run_event(3, 60, 1'b0, -1, -1);
            repeat ($urandom_range(4, 0)) tick();
        end
        chk("t2_busy_armed", 32'(busy), 32'd1);
        disarm = 1'b1; tick(); disarm = 1'b0;
        drain();
        chk("t2_event_cnt", 32'(event_cnt), 32'(mdl_ev));
        chk("t2_busy_idle", 32'(busy), 32'd0);

        // T3: no room at 16380, room at 16379
        fake_fill = 16380;
        do_arm(4, 1'b0);
        we0 = we_count;
        run_event(4, 100, 1'b0, -1, -1);
        repeat (3) tick();
        chk("t3_drop_cnt", 32'(drop_cnt), 32'(mdl_drop));
        chk("t3_no_write", 32'(we_count - we0), 32'd0);
        chk("t3_still_armed", 32'(busy), 32'd1);
        fake_fill = 16379;
        run_event(4, 100, 1'b0, -1, -1);
        drain();
        chk("t3_accept_writes", 32'(we_count - we0), 32'd5);
        chk("t3_event_cnt", 32'(event_cnt), 32'(mdl_ev));
        fake_fill = 0;

        // T4: 100-sample event with random backpressure
        rnd_ready = 1'b1;
        do_arm(100, 1'b0);
        run_event(100, 70, 1'b0, -1, -1);
        drain();
        rnd_ready = 1'b0;
        chk("t4_event_cnt", 32'(event_cnt), 32'(mdl_ev));

        // T5: trigger and disarm during capture, continuous mode
        do_arm(8, 1'b1);
        run_event(8, 80, 1'b0, 3, 5);
        drain();
        chk("t5_drop_cnt", 32'(drop_cnt), 32'(mdl_drop));
        chk("t5_event_cnt", 32'(event_cnt), 32'(mdl_ev));
        chk("t5_busy_idle", 32'(busy), 32'd0);

        // Random events, including N=1
        for (int e = 0; e < 6; e++) begin
            n = (e == 0) ? 1 : $urandom_range(20, 1);
            rnd_ready = 1'($urandom_range(1, 0));
            do_arm(n, 1'b0);
            run_event(n, $urandom_range(100, 30), 1'b0,
                      ($urandom_range(1, 0) != 0) ? $urandom_range(n - 1, 0) : -1, -1);
            drain();
            chk("rnd_event_cnt", 32'(event_cnt), 32'(mdl_ev));
            chk("rnd_drop_cnt", 32'(drop_cnt), 32'(mdl_drop));
        end
        rnd_ready = 1'b0;

        // T6: reset in the middle of a capture
        do_arm(10, 1'b0);
        trig = 1'b1; tick(); trig = 1'b0; tick();
        svalid = 1'b1;
        repeat (3) begin sdata = 16'($urandom); tick(); end
        trig = 1'b1; tick(); trig = 1'b0;
        reset = 1'b1; svalid = 1'b0;
        tick();
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_last",  32'(out_last),  32'd0);
        chk("t6_fifo_we",   32'(fifo_we),   32'd0);
        chk("t6_fifo_re",   32'(fifo_re),   32'd0);
        chk("t6_busy",      32'(busy),      32'd0);
        chk("t6_event_cnt", 32'(event_cnt), 32'd0);
        chk("t6_drop_cnt",  32'(drop_cnt),  32'd0);
        reset = 1'b0;
        exp_q.delete();
        mdl_ev = 0;
        mdl_drop = 0;
        tick();
        do_arm(4, 1'b0);
        run_event(4, 100, 1'b1, -1, -1);
        drain();
        chk("t6_event_cnt_after", 32'(event_cnt), 32'd1);
        chk("t6_busy_after", 32'(busy), 32'd0);

        chk("fifo_full_writes", 32'(full_viol), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
